// File: rtl/axis_packetizer.sv
// AXI-Stream packetizer: frames a raw beat stream into packets of (i_pktlen+1) beats.
// Optional early-last support when AXIS_PKT_EARLYLAST_EN is defined.
module axis_packetizer #(
  parameter int DW       = 16,
  parameter int LGMAXLEN = 8
) (
  input  logic                S_AXI_ACLK,
  input  logic                S_AXI_ARESET,
  input  logic [LGMAXLEN-1:0] i_pktlen,
  input  logic                S_AXIS_TVALID,
  output logic                S_AXIS_TREADY,
  input  logic [DW-1:0]       S_AXIS_TDATA,
  input  logic                S_AXIS_TLAST,
  output logic                M_AXIS_TVALID,
  input  logic                M_AXIS_TREADY,
  output logic [DW-1:0]       M_AXIS_TDATA,
  output logic                M_AXIS_TLAST,
  output logic [31:0]         o_pkt_count
);

  logic [LGMAXLEN-1:0] cnt_q, cnt_d;
  logic [LGMAXLEN-1:0] len_q, len_d;
  logic                s_ready_q, s_ready_d;
  logic                out_valid_q, out_valid_d;
  logic [DW-1:0]       out_data_q, out_data_d;
  logic                out_last_q, out_last_d;
  logic                skid_valid_q, skid_valid_d;
  logic [DW-1:0]       skid_data_q, skid_data_d;
  logic                skid_last_q, skid_last_d;
  logic [31:0]         pkt_count_q, pkt_count_d;

  logic                in_fire;
  logic                out_fire;
  logic                first_beat;
  logic [LGMAXLEN-1:0] cur_len;
  logic                in_last;

`ifndef AXIS_PKT_EARLYLAST_EN
  logic unused_tlast;
  assign unused_tlast = S_AXIS_TLAST;
`endif

  assign in_fire    = S_AXIS_TVALID && s_ready_q;
  assign out_fire   = out_valid_q && M_AXIS_TREADY;
  assign first_beat = (cnt_q == '0);
  // The first beat of a packet sees i_pktlen live; later beats use the latched copy.
  assign cur_len    = first_beat ? i_pktlen : len_q;

  always_comb begin
    in_last = (cnt_q == cur_len);
`ifdef AXIS_PKT_EARLYLAST_EN
    if (S_AXIS_TLAST) in_last = 1'b1;
`endif

    cnt_d        = cnt_q;
    len_d        = len_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_last_d  = skid_last_q;
    pkt_count_d  = pkt_count_q;

    if (in_fire) begin
      if (first_beat) len_d = i_pktlen;
      cnt_d = in_last ? '0 : cnt_q + 1'b1;
    end

    if (!out_valid_q || out_fire) begin
      // Skid beat is older than anything arriving now; while it is held the
      // input is not ready, so in_fire cannot coincide with it.
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        out_last_d   = skid_last_q;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        out_valid_d = 1'b1;
        out_data_d  = S_AXIS_TDATA;
        out_last_d  = in_last;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_valid_d = 1'b1;
      skid_data_d  = S_AXIS_TDATA;
      skid_last_d  = in_last;
    end

    s_ready_d = !skid_valid_d;

    if (out_fire && out_last_q) pkt_count_d = pkt_count_q + 32'd1;
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      cnt_q        <= '0;
      len_q        <= '0;
      s_ready_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_last_q  <= 1'b0;
      pkt_count_q  <= '0;
    end else begin
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      s_ready_q    <= s_ready_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_last_q  <= skid_last_d;
      pkt_count_q  <= pkt_count_d;
    end
  end

  assign S_AXIS_TREADY = s_ready_q;
  assign M_AXIS_TVALID = out_valid_q;
  assign M_AXIS_TDATA  = out_data_q;
  assign M_AXIS_TLAST  = out_last_q;
  assign o_pkt_count   = pkt_count_q;

endmodule

// File: tb/tb_axis_packetizer.sv
// Bench for axis_packetizer: packet-position model plus directed scenarios.
// Honours AXIS_PKT_EARLYLAST_EN when the build defines it.
module tb_axis_packetizer;

  localparam int DW = 16;
  localparam int LG = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [LG-1:0] i_pktlen;
  logic          s_valid, s_ready, s_last;
  logic [DW-1:0] s_data;
  logic          m_valid, m_ready, m_last;
  logic [DW-1:0] m_data;
  logic [31:0]   pkt_count;

  axis_packetizer #(.DW(DW), .LGMAXLEN(LG)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst), .i_pktlen(i_pktlen),
    .S_AXIS_TVALID(s_valid), .S_AXIS_TREADY(s_ready), .S_AXIS_TDATA(s_data),
    .S_AXIS_TLAST(s_last), .M_AXIS_TVALID(m_valid), .M_AXIS_TREADY(m_ready),
    .M_AXIS_TDATA(m_data), .M_AXIS_TLAST(m_last), .o_pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: expected output beats, packet position and packet target length.
  logic [DW:0]   exp_q[$];
  int            pos = 0;
  int            target = 1;
  logic [31:0]   m_count = 0;
  bit            last_log[256];
  bit            seen_log[256];
  bit            tready_low_seen = 0;
  logic          p_valid = 0, p_ready = 0, p_last = 0, p_tready = 0, p_skidfill = 0;
  logic [DW-1:0] p_data = 0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      pos = 0;
      m_count = 0;
      p_valid = 0; p_ready = 0; p_tready = 0; p_skidfill = 0;
    end else begin
      if (p_valid && !p_ready) begin
        check("stall_valid", m_valid, 1'b1);
        check("stall_data", m_data, p_data);
        check("stall_last", m_last, p_last);
      end
      if (p_tready && !s_ready && !p_skidfill)
        check("tready_drop_without_skid", 1'b0, 1'b1);
      if (!s_ready) tready_low_seen = 1;
      check("pkt_count", pkt_count, m_count);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", m_data, {DW{1'b1}});
        end else begin
          logic [DW:0] e;
          e = exp_q.pop_front();
          check("out_data", m_data, e[DW-1:0]);
          check("out_last", m_last, e[DW]);
          if (e[DW]) m_count = m_count + 1;
        end
        last_log[m_data[7:0]] = m_last;
        seen_log[m_data[7:0]] = 1'b1;
      end
      if (s_valid && s_ready) begin
        bit l;
        if (pos == 0) target = int'(i_pktlen) + 1;
        pos++;
        l = (pos == target);
`ifdef AXIS_PKT_EARLYLAST_EN
        if (s_last) l = 1'b1;
`endif
        if (l) pos = 0;
        exp_q.push_back({l, s_data});
      end
      p_skidfill = s_valid && s_ready && m_valid && !m_ready;
      p_valid = m_valid; p_ready = m_ready; p_last = m_last; p_data = m_data;
      p_tready = s_ready;
    end
  end

  bit tog_mode = 0;
  int stalls = 0;

  task automatic step();
    @(posedge clk); #1;
    if (tog_mode) m_ready = ~m_ready;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic tl);
    bit acc;
    acc = 0;
    s_valid = 1'b1; s_data = d; s_last = tl;
    for (int w = 0; w < 100; w++) begin
      @(negedge clk);
      acc = s_ready;
      step();
      if (acc) break;
      stalls++;
    end
    if (!acc) check("accept_timeout", 1'b0, 1'b1);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || m_valid) && k < 600) begin
      step();
      k++;
    end
    if (k >= 600) check("drain_timeout", 1'b0, 1'b1);
  endtask

  task automatic clear_logs();
    for (int i = 0; i < 256; i++) begin
      last_log[i] = 0;
      seen_log[i] = 0;
    end
  endtask

  logic [31:0] base;

  initial begin
    rst = 1; i_pktlen = 0; s_valid = 0; s_data = 0; s_last = 0; m_ready = 1;
    step(); step();
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_last", m_last, 1'b0);
    check("rst_m_data", m_data, 16'h0);
    check("rst_s_ready", s_ready, 1'b0);
    check("rst_count", pkt_count, 32'd0);
    rst = 0;
    check("ready_before_clock", s_ready, 1'b0);
    step();
    check("ready_after_release", s_ready, 1'b1);

    // 1: length 4, full throughput
    clear_logs(); base = pkt_count; i_pktlen = 3; stalls = 0;
    for (int i = 0; i < 8; i++) send_beat(DW'(i), 1'b0);
    drain();
    check("t1_stalls", stalls, 0);
    check("t1_last3", last_log[3], 1'b1);
    check("t1_last7", last_log[7], 1'b1);
    check("t1_last2", last_log[2], 1'b0);
    check("t1_count", pkt_count - base, 32'd2);

    // 2: length 2, downstream ready toggling
    clear_logs(); i_pktlen = 1; tready_low_seen = 0; tog_mode = 1;
    for (int i = 0; i < 6; i++) send_beat(DW'(i), 1'b0);
    drain();
    tog_mode = 0; m_ready = 1;
    for (int i = 0; i < 6; i++) begin
      check("t2_seen", seen_log[i], 1'b1);
      check("t2_last", last_log[i], (i % 2) == 1);
    end
    check("t2_skid_used", tready_low_seen, 1'b1);

    // 3: length change mid-packet
    clear_logs(); i_pktlen = 4;
    for (int i = 0; i < 7; i++) begin
      send_beat(DW'(i), 1'b0);
      if (i == 2) i_pktlen = 1;
    end
    drain();
    check("t3_last3", last_log[3], 1'b0);
    check("t3_last4", last_log[4], 1'b1);
    check("t3_last5", last_log[5], 1'b0);
    check("t3_last6", last_log[6], 1'b1);

    // 4: every beat is last
    clear_logs(); base = pkt_count; i_pktlen = 0;
    for (int i = 0; i < 5; i++) send_beat(DW'(i), 1'b0);
    drain();
    for (int i = 0; i < 5; i++) check("t4_last", last_log[i], 1'b1);
    check("t4_count", pkt_count - base, 32'd5);

    // maximum length: 256 beats
    clear_logs(); base = pkt_count; i_pktlen = 8'hFF;
    for (int i = 0; i < 256; i++) send_beat(DW'(i), 1'b0);
    drain();
    check("max_last0", last_log[0], 1'b0);
    check("max_last254", last_log[254], 1'b0);
    check("max_last255", last_log[255], 1'b1);
    check("max_count", pkt_count - base, 32'd1);

    // 6: input TLAST on beat 2
    clear_logs(); i_pktlen = 7;
    for (int i = 0; i < 11; i++) send_beat(DW'(i), i == 2);
    drain();
`ifdef AXIS_PKT_EARLYLAST_EN
    check("t6_last2", last_log[2], 1'b1);
    check("t6_last7", last_log[7], 1'b0);
    check("t6_last10", last_log[10], 1'b1);
`else
    check("t6_last2", last_log[2], 1'b0);
    check("t6_last7", last_log[7], 1'b1);
    check("t6_last10", last_log[10], 1'b0);
`endif

    // 5: reset mid-packet with output stalled
    clear_logs(); i_pktlen = 3; m_ready = 0;
    send_beat(16'h00, 1'b0);
    send_beat(16'h01, 1'b0);
    check("t5_stalled_valid", m_valid, 1'b1);
    rst = 1;
    #1;
    check("t5_rst_valid", m_valid, 1'b0);
    check("t5_rst_ready", s_ready, 1'b0);
    check("t5_rst_count", pkt_count, 32'd0);
    step(); step();
    rst = 0; m_ready = 1;
    step();
    check("t5_ready_back", s_ready, 1'b1);
    clear_logs();
    for (int i = 0; i < 4; i++) send_beat(DW'(16'h10 + i), 1'b0);
    drain();
    check("t5_last_b2", last_log[8'h12], 1'b0);
    check("t5_last_b3", last_log[8'h13], 1'b1);
    check("t5_count", pkt_count, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
